heap_mem: RTL and testbench

Tagged-word heap memory that serves the evaluator core's memory traffic. The core issues READ, WRITE and CONS requests over a valid/ready request channel. The block returns a single-cycle response pulse carrying the data word or a freshly allocated cons pointer. It owns the 16-bit word store and the bump-allocation free pointer, and it sits directly downstream of the core's FETCH/EVAL states.

---
 rtl/heap_mem.sv | 180 ++++++++++++++++++
 tb/tb_heap_mem.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/heap_mem.sv
// heap_mem: tagged-word heap store serving READ, WRITE and CONS requests with bump allocation.
// Optional macro HEAP_CLEAR_ON_RESET_EN adds an INIT sweep that zeroes the store after reset.
module heap_mem #(
  parameter int         DEPTH     = 256,
  parameter int         HEAP_BASE = 16,
  parameter logic [2:0] TAG_CONS  = 3'b001
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [1:0]  REQ_OP,
  input  logic [11:0] REQ_ADDR,
  input  logic [15:0] REQ_DATA_A,
  input  logic [15:0] REQ_DATA_B,
  output logic        RSP_VALID,
  output logic [15:0] RSP_DATA,
  output logic        RSP_ERR,
  output logic [11:0] FREE_PTR,
  output logic        HEAP_FULL
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
`ifdef HEAP_CLEAR_ON_RESET_EN
    INIT,
`endif
    IDLE,
    RD,
    CONS2,
    RESP
  } state_t;

`ifdef HEAP_CLEAR_ON_RESET_EN
  localparam state_t RESET_STATE = INIT;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  logic [AW-1:0] init_addr;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t        state;
  state_t        state_next;
  logic [15:0]   mem [DEPTH];
  logic [11:0]   free_ptr;
  logic [AW-1:0] cdr_addr;
  logic [AW-1:0] addr_q;
  logic [15:0]   data_b_q;
  logic [15:0]   rsp_data_q;
  logic          rsp_err_q;
  logic          accept;
  logic          addr_ok;
  logic          do_read;
  logic          do_write;
  logic          do_cons;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [15:0]   mem_wdata;

  assign FREE_PTR  = free_ptr;
  assign HEAP_FULL = {20'd0, free_ptr} > 32'(DEPTH - 2);
  assign cdr_addr  = free_ptr[AW-1:0] + AW'(1);
  assign addr_ok   = {20'd0, REQ_ADDR} < 32'(DEPTH);
  // Acceptance is decoded from state rather than REQ_READY to keep the comb paths acyclic.
  assign accept    = REQ_VALID && (state == IDLE) && !RST;
  assign do_read   = accept && (REQ_OP == 2'b00) && addr_ok;
  assign do_write  = accept && (REQ_OP == 2'b01) && addr_ok;
  assign do_cons   = accept && (REQ_OP == 2'b10) && !HEAP_FULL;

  always_ff @(posedge CLK) begin
    if (RST) state <= RESET_STATE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
`ifdef HEAP_CLEAR_ON_RESET_EN
      INIT:      if (init_addr == LAST_ADDR) state_next = IDLE;
`endif
      IDLE: begin
        if (accept) begin
          if (do_read)      state_next = RD;
          else if (do_cons) state_next = CONS2;
          else              state_next = RESP;
        end
      end
      RD, CONS2: state_next = RESP;
      RESP:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    REQ_READY = 1'b0;
    RSP_VALID = 1'b0;
    RSP_DATA  = 16'h0000;
    RSP_ERR   = 1'b0;
    case (state)
      IDLE: REQ_READY = !RST;
      RESP: begin
        RSP_VALID = 1'b1;
        RSP_DATA  = rsp_data_q;
        RSP_ERR   = rsp_err_q;
      end
      default: ;
    endcase
  end

  // Single write port; reset suppresses every write, including a pending cdr.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = 16'h0000;
    if (!RST) begin
      case (state)
        IDLE: begin
          if (do_write) begin
            mem_we    = 1'b1;
            mem_waddr = REQ_ADDR[AW-1:0];
            mem_wdata = REQ_DATA_A;
          end else if (do_cons) begin
            mem_we    = 1'b1;
            mem_waddr = free_ptr[AW-1:0];
            mem_wdata = REQ_DATA_A;
          end
        end
        CONS2: begin
          mem_we    = 1'b1;
          mem_waddr = cdr_addr;
          mem_wdata = data_b_q;
        end
`ifdef HEAP_CLEAR_ON_RESET_EN
        INIT: begin
          mem_we    = 1'b1;
          mem_waddr = init_addr;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      free_ptr   <= 12'(HEAP_BASE);
      addr_q     <= '0;
      data_b_q   <= 16'h0000;
      rsp_data_q <= 16'h0000;
      rsp_err_q  <= 1'b0;
`ifdef HEAP_CLEAR_ON_RESET_EN
      init_addr  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q     <= REQ_ADDR[AW-1:0];
            data_b_q   <= REQ_DATA_B;
            rsp_data_q <= 16'h0000;
            rsp_err_q  <= !(do_read || do_write || do_cons);
          end
        end
        RD: rsp_data_q <= mem[addr_q];
        CONS2: begin
          rsp_data_q <= {1'b0, TAG_CONS, free_ptr};
          free_ptr   <= free_ptr + 12'd2;
        end
`ifdef HEAP_CLEAR_ON_RESET_EN
        INIT: init_addr <= init_addr + AW'(1);
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_heap_mem.sv
// tb_heap_mem: directed vector table plus hand-written full-heap and mid-CONS reset sequences.
module tb_heap_mem;
  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_CONS = 2'b10;
  localparam logic [1:0] OP_BAD = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [11:0] req_addr;
  logic [15:0] req_data_a;
  logic [15:0] req_data_b;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [11:0] free_ptr;
  logic        heap_full;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [15:0] a;
    logic [15:0] b;
    bit          hold;
    logic [15:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    logic [11:0] exp_fp;
  } vec_t;

  vec_t vecs[17];

  always #5 clk = ~clk;

  heap_mem dut (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_READY(req_ready),
    .REQ_OP(req_op), .REQ_ADDR(req_addr), .REQ_DATA_A(req_data_a),
    .REQ_DATA_B(req_data_b), .RSP_VALID(rsp_valid), .RSP_DATA(rsp_data),
    .RSP_ERR(rsp_err), .FREE_PTR(free_ptr), .HEAP_FULL(heap_full)
  );

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Issues one request and waits a bounded number of cycles for its response pulse.
  task automatic apply_stimulus(input logic [1:0] op, input logic [11:0] addr,
                                input logic [15:0] a, input logic [15:0] b, input bit hold,
                                output logic [15:0] data, output logic err, output int lat);
    req_op = op;
    req_addr = addr;
    req_data_a = a;
    req_data_b = b;
    req_valid = 1'b1;
    data = 16'h0000;
    err = 1'b0;
    lat = -1;
    @(posedge clk);
    for (int i = 1; i <= 6 && lat < 0; i++) begin
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
      if (rsp_valid) begin
        lat = i;
        data = rsp_data;
        err = rsp_err;
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    if (lat >= 0) begin
      @(negedge clk);
      check_output("rsp_pulse_width", {31'd0, rsp_valid}, 32'd0);
      check_output("ready_after_resp", {31'd0, req_ready}, 32'd1);
    end else begin
      checks++;
      failures++;
      $display("[TB] FAIL rsp_timeout: got no response, expected one within 6 cycles");
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_output("rst_ready", {31'd0, req_ready}, 32'd0);
    check_output("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_output("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check_output("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
    check_output("rst_free_ptr", {20'd0, free_ptr}, 32'h010);
    check_output("rst_heap_full", {31'd0, heap_full}, 32'd0);
    rst = 1'b0;
    #1;
    check_output("ready_first_cycle", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] d;
    logic        e;
    int          lat;
    logic [11:0] fp_model;
    bit          seen;

    vecs[0]  = '{OP_WR,   12'h001, 16'hBEEF, 16'h0000, 1'b0, 16'h0000, 1'b0, 1, 12'h010};
    vecs[1]  = '{OP_RD,   12'h001, 16'h0000, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 2, 12'h010};
    vecs[2]  = '{OP_CONS, 12'h000, 16'h0005, 16'h0000, 1'b0, 16'h1010, 1'b0, 2, 12'h012};
    vecs[3]  = '{OP_RD,   12'h010, 16'h0000, 16'h0000, 1'b0, 16'h0005, 1'b0, 2, 12'h012};
    vecs[4]  = '{OP_RD,   12'h011, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 2, 12'h012};
    vecs[5]  = '{OP_WR,   12'h0FF, 16'h5A5A, 16'h0000, 1'b0, 16'h0000, 1'b0, 1, 12'h012};
    vecs[6]  = '{OP_RD,   12'h0FF, 16'h0000, 16'h0000, 1'b0, 16'h5A5A, 1'b0, 2, 12'h012};
    vecs[7]  = '{OP_WR,   12'h000, 16'hC0DE, 16'h0000, 1'b0, 16'h0000, 1'b0, 1, 12'h012};
    vecs[8]  = '{OP_RD,   12'h100, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1, 12'h012};
    vecs[9]  = '{OP_WR,   12'h100, 16'h1111, 16'h0000, 1'b0, 16'h0000, 1'b1, 1, 12'h012};
    vecs[10] = '{OP_BAD,  12'h001, 16'hDDDD, 16'hEEEE, 1'b1, 16'h0000, 1'b1, 1, 12'h012};
    vecs[11] = '{OP_RD,   12'h000, 16'h0000, 16'h0000, 1'b0, 16'hC0DE, 1'b0, 2, 12'h012};
    vecs[12] = '{OP_RD,   12'h001, 16'h0000, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 2, 12'h012};
    vecs[13] = '{OP_CONS, 12'h3FF, 16'hAAAA, 16'hBBBB, 1'b0, 16'h1012, 1'b0, 2, 12'h014};
    vecs[14] = '{OP_RD,   12'h012, 16'h0000, 16'h0000, 1'b0, 16'hAAAA, 1'b0, 2, 12'h014};
    vecs[15] = '{OP_RD,   12'h013, 16'h0000, 16'h0000, 1'b0, 16'hBBBB, 1'b0, 2, 12'h014};
    vecs[16] = '{OP_RD,   12'hFFF, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1, 12'h014};

    rst = 1'b1;
    req_valid = 1'b0;
    req_op = OP_RD;
    req_addr = 12'h000;
    req_data_a = 16'h0000;
    req_data_b = 16'h0000;
    do_reset();

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].op, vecs[i].addr, vecs[i].a, vecs[i].b, vecs[i].hold, d, e, lat);
      check_output($sformatf("vec%0d_data", i), {16'd0, d}, {16'd0, vecs[i].exp_data});
      check_output($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
      check_output($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      check_output($sformatf("vec%0d_free_ptr", i), {20'd0, free_ptr}, {20'd0, vecs[i].exp_fp});
    end

    // Allocate until the heap is exhausted.
    fp_model = 12'h014;
    for (int n = 0; n < 200 && fp_model < 12'h100; n++) begin
      check_output($sformatf("fill%0d_full", n), {31'd0, heap_full},
                   {31'd0, (fp_model > 12'd254)});
      apply_stimulus(OP_CONS, 12'h000, {4'h0, fp_model}, ~{4'h0, fp_model}, 1'b0, d, e, lat);
      check_output($sformatf("fill%0d_ptr", n), {16'd0, d}, {16'd0, 4'h1, fp_model});
      check_output($sformatf("fill%0d_err", n), {31'd0, e}, 32'd0);
      check_output($sformatf("fill%0d_latency", n), lat, 2);
      fp_model = fp_model + 12'd2;
      check_output($sformatf("fill%0d_free_ptr", n), {20'd0, free_ptr}, {20'd0, fp_model});
    end
    check_output("full_free_ptr", {20'd0, free_ptr}, 32'h100);
    check_output("full_flag", {31'd0, heap_full}, 32'd1);
    apply_stimulus(OP_CONS, 12'h000, 16'h7E7E, 16'h7F7F, 1'b0, d, e, lat);
    check_output("cons_full_err", {31'd0, e}, 32'd1);
    check_output("cons_full_data", {16'd0, d}, 32'd0);
    check_output("cons_full_latency", lat, 1);
    check_output("cons_full_free_ptr", {20'd0, free_ptr}, 32'h100);
    apply_stimulus(OP_RD, 12'h0FE, 16'h0000, 16'h0000, 1'b0, d, e, lat);
    check_output("last_car", {16'd0, d}, 32'h00FE);
    apply_stimulus(OP_RD, 12'h0FF, 16'h0000, 16'h0000, 1'b0, d, e, lat);
    check_output("last_cdr", {16'd0, d}, 32'hFF01);

    // Reset in the CONS2 cycle: car stays, cdr is dropped, no response.
    do_reset();
    apply_stimulus(OP_WR, 12'h011, 16'h7777, 16'h0000, 1'b0, d, e, lat);
    req_op = OP_CONS;
    req_data_a = 16'h4444;
    req_data_b = 16'h9999;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_output("cons2_no_rsp_yet", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_output("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_output("abort_free_ptr", {20'd0, free_ptr}, 32'h010);
    rst = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check_output("abort_no_response", {31'd0, seen}, 32'd0);
    apply_stimulus(OP_RD, 12'h011, 16'h0000, 16'h0000, 1'b0, d, e, lat);
    check_output("abort_cdr_untouched", {16'd0, d}, 32'h7777);
    apply_stimulus(OP_RD, 12'h010, 16'h0000, 16'h0000, 1'b0, d, e, lat);
    check_output("abort_car_kept", {16'd0, d}, 32'h4444);
    check_output("abort_free_ptr_after", {20'd0, free_ptr}, 32'h010);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
